// File: rtl/fan_pkg.sv
// Shared fan-control state encoding, default constants and the duty clamp helper.
// Declarations only: no latency and no flow control live here.
package fan_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        KICK  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } fan_state_e;

    localparam int PERIOD_DEF       = 10000;
    localparam int CW_DEF           = 14;
    localparam int RAMP_STEP_DEF    = 100;
    localparam int KICK_PERIODS_DEF = 8;
    localparam int TACH_TIMEOUT_DEF = 4;
    localparam int T_LOW_DEF        = 40;
    localparam int T_MID_DEF        = 55;
    localparam int T_HIGH_DEF       = 70;
    localparam int DUTY_LOW_DEF     = 4000;
    localparam int DUTY_MID_DEF     = 6000;
    localparam int DUTY_HIGH_DEF    = 8000;

    // A duty above the period would just mean "always on", so saturate it there.
    function automatic logic [31:0] clamp_duty(input logic [31:0] duty,
                                               input logic [31:0] period);
        return (duty > period) ? period : duty;
    endfunction

endpackage

// File: rtl/fan_speed_sched_if.sv
// Temperature sample handshake from the sensor reader into the fan scheduler.
// The scheduler side always accepts, so the reader never sees backpressure.
interface fan_speed_sched_if;
    logic       temp_valid_i;
    logic [7:0] temp_i;
    logic       temp_ready_o;

    modport master (output temp_valid_i, output temp_i, input temp_ready_o);
    modport slave  (input temp_valid_i, input temp_i, output temp_ready_o);
endinterface

// File: rtl/fan_pwm_gen.sv
// PWM period counter with boundary strobe; duty is latched only at the boundary.
// Output is one cycle behind the counter compare; no handshake, free running.
module fan_pwm_gen #(
    parameter int PERIOD = fan_pkg::PERIOD_DEF,
    parameter int CW     = fan_pkg::CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] duty_next,
    output logic          boundary,
    output logic [CW-1:0] duty,
    output logic          fan_ctl
);

    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
    localparam logic [CW-1:0] FULL = CW'(PERIOD);

    logic [CW-1:0] cnt_q;

    assign boundary = (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            duty    <= FULL;
            fan_ctl <= 1'b1;
        end else begin
            cnt_q   <= boundary ? '0 : cnt_q + CW'(1);
            if (boundary) begin
                duty <= duty_next;
            end
            fan_ctl <= (cnt_q < duty);
        end
    end

endmodule

// File: rtl/fan_speed_sched.sv
// Closed-loop fan scheduler: temp->target map, slewed duty, kick-start and tach stall watch.
// Duty moves only at PWM boundaries; temp samples always accepted. FAN_OVERRIDE_EN adds a duty override.
module fan_speed_sched
    import fan_pkg::*;
#(
    parameter int PERIOD       = PERIOD_DEF,
    parameter int CW           = CW_DEF,
    parameter int RAMP_STEP    = RAMP_STEP_DEF,
    parameter int KICK_PERIODS = KICK_PERIODS_DEF,
    parameter int TACH_TIMEOUT = TACH_TIMEOUT_DEF,
    parameter int T_LOW        = T_LOW_DEF,
    parameter int T_MID        = T_MID_DEF,
    parameter int T_HIGH       = T_HIGH_DEF,
    parameter int DUTY_LOW     = DUTY_LOW_DEF,
    parameter int DUTY_MID     = DUTY_MID_DEF,
    parameter int DUTY_HIGH    = DUTY_HIGH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    fan_speed_sched_if.slave    temp_if,
    input  logic                tach_i,
    input  logic                stall_clr_i,
`ifdef FAN_OVERRIDE_EN
    input  logic                ovr_en_i,
    input  logic [CW-1:0]       ovr_duty_i,
`endif
    output logic                fan_ctl_o,
    output logic [CW-1:0]       duty_o,
    output logic                stall_o,
    output logic [STATE_W-1:0]  state_o
);

    localparam int KW = $clog2(KICK_PERIODS + 1);
    localparam int MW = $clog2(TACH_TIMEOUT + 1);

    localparam logic [CW-1:0] FULL   = CW'(PERIOD);
    localparam logic [CW-1:0] STEP_C = CW'(RAMP_STEP);
    localparam logic [CW:0]   STEP_W = (CW+1)'(RAMP_STEP);
    localparam logic [7:0]    TL     = 8'(T_LOW);
    localparam logic [7:0]    TM     = 8'(T_MID);
    localparam logic [7:0]    TH     = 8'(T_HIGH);

    fan_state_e     state_q;
    logic [KW-1:0]  kick_q;
    logic [MW-1:0]  miss_q;
    logic           seen_q;
    logic           stall_q;
    logic [CW-1:0]  cur_q;
    logic [CW-1:0]  target_q;
    logic           tach_s1, tach_s2, tach_prev;

    logic           boundary;
    logic           tach_edge, seen_eff, stall_hit;
    logic           temp_accept;
    logic [CW-1:0]  temp_duty, slew_duty, duty_next;
    logic [CW:0]    up_w, tgt_hi_w;

    assign temp_if.temp_ready_o = 1'b1;
    assign temp_accept          = temp_if.temp_valid_i & temp_if.temp_ready_o;

    always_comb begin
        temp_duty = FULL;
        if (temp_if.temp_i < TL) begin
            temp_duty = CW'(DUTY_LOW);
        end else if (temp_if.temp_i < TM) begin
            temp_duty = CW'(DUTY_MID);
        end else if (temp_if.temp_i < TH) begin
            temp_duty = CW'(DUTY_HIGH);
        end
    end

`ifdef FAN_OVERRIDE_EN
    logic ovr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            target_q <= FULL;
            ovr_q    <= 1'b0;
        end else begin
            ovr_q <= ovr_en_i;
            if (ovr_en_i) begin
                target_q <= CW'(clamp_duty(32'(ovr_duty_i), 32'(PERIOD)));
            end else if (temp_accept) begin
                target_q <= temp_duty;
            end else if (ovr_q) begin
                target_q <= FULL;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            target_q <= FULL;
        end else if (temp_accept) begin
            target_q <= temp_duty;
        end
    end
`endif

    // Sums carry an extra bit so cur+step and target+step never wrap.
    always_comb begin
        up_w      = {1'b0, cur_q} + STEP_W;
        tgt_hi_w  = {1'b0, target_q} + STEP_W;
        slew_duty = cur_q;
        if (cur_q < target_q) begin
            slew_duty = (up_w > {1'b0, target_q}) ? target_q : up_w[CW-1:0];
        end else if (cur_q > target_q) begin
            slew_duty = ({1'b0, cur_q} > tgt_hi_w) ? cur_q - STEP_C : target_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tach_s1   <= 1'b0;
            tach_s2   <= 1'b0;
            tach_prev <= 1'b0;
        end else begin
            tach_s1   <= tach_i;
            tach_s2   <= tach_s1;
            tach_prev <= tach_s2;
        end
    end

    // An edge landing on the boundary cycle still belongs to the ending period.
    assign tach_edge = tach_s2 & ~tach_prev;
    assign seen_eff  = seen_q | tach_edge;
    assign stall_hit = (state_q == RUN) && boundary && !seen_eff &&
                       (miss_q + MW'(1) == MW'(TACH_TIMEOUT));
    assign duty_next = ((state_q == RUN) && !stall_hit) ? slew_duty : FULL;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= KICK;
            kick_q  <= '0;
            miss_q  <= '0;
            seen_q  <= 1'b0;
            stall_q <= 1'b0;
            cur_q   <= FULL;
        end else begin
            case (state_q)
                KICK: begin
                    seen_q <= 1'b0;
                    if (boundary) begin
                        if (kick_q == KW'(KICK_PERIODS - 1)) begin
                            state_q <= RUN;
                            kick_q  <= '0;
                            miss_q  <= '0;
                            cur_q   <= FULL;
                        end else begin
                            kick_q <= kick_q + KW'(1);
                        end
                    end
                end
                RUN: begin
                    if (boundary) begin
                        seen_q <= 1'b0;
                        if (stall_hit) begin
                            state_q <= STALL;
                            stall_q <= 1'b1;
                            miss_q  <= '0;
                            cur_q   <= FULL;
                        end else begin
                            miss_q <= seen_eff ? '0 : miss_q + MW'(1);
                            cur_q  <= slew_duty;
                        end
                    end else if (tach_edge) begin
                        seen_q <= 1'b1;
                    end
                end
                STALL: begin
                    seen_q <= 1'b0;
                    if (stall_clr_i) begin
                        stall_q <= 1'b0;
                        state_q <= KICK;
                        kick_q  <= '0;
                    end
                end
                default: state_q <= KICK;
            endcase
        end
    end

    assign stall_o = stall_q;
    assign state_o = state_q;

    fan_pwm_gen #(
        .PERIOD (PERIOD),
        .CW     (CW)
    ) u_pwm (
        .clk       (clk),
        .reset     (reset),
        .duty_next (duty_next),
        .boundary  (boundary),
        .duty      (duty_o),
        .fan_ctl   (fan_ctl_o)
    );

endmodule

// File: tb/tb_fan_speed_sched.sv
// Bench for fan_speed_sched with shortened PWM period; per-cycle reference model plus directed sequences.
module tb_fan_speed_sched;

    localparam int P     = 100;
    localparam int CW    = 14;
    localparam int STEP  = 10;
    localparam int KP    = 2;
    localparam int TO    = 3;
    localparam int T_LO  = 40;
    localparam int T_MI  = 60;
    localparam int T_HI  = 80;
    localparam int D_LO  = 40;
    localparam int D_MI  = 60;
    localparam int D_HI  = 80;

    logic          clk = 1'b0;
    logic          drv_rst = 1'b1;
    logic          drv_tv = 1'b0;
    logic [7:0]    drv_temp = 8'd0;
    logic          drv_tach = 1'b0;
    logic          drv_clr = 1'b0;
    logic          fan_ctl;
    logic [CW-1:0] duty;
    logic          stall;
    logic [1:0]    state;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int tach_mode = 1;

    // reference model state (spec-level quantities)
    int m_cnt, m_duty, m_fan, m_state, m_stall, m_kick, m_miss, m_seen, m_cur, m_tgt;
    bit th [3];

    always #5 clk = ~clk;

    fan_speed_sched_if tif ();
    assign tif.temp_valid_i = drv_tv;
    assign tif.temp_i       = drv_temp;

    fan_speed_sched #(
        .PERIOD(P), .CW(CW), .RAMP_STEP(STEP), .KICK_PERIODS(KP), .TACH_TIMEOUT(TO),
        .T_LOW(T_LO), .T_MID(T_MI), .T_HIGH(T_HI),
        .DUTY_LOW(D_LO), .DUTY_MID(D_MI), .DUTY_HIGH(D_HI)
    ) dut (
        .clk         (clk),
        .reset       (drv_rst),
        .temp_if     (tif.slave),
        .tach_i      (drv_tach),
        .stall_clr_i (drv_clr),
`ifdef FAN_OVERRIDE_EN
        .ovr_en_i    (1'b0),
        .ovr_duty_i  ('0),
`endif
        .fan_ctl_o   (fan_ctl),
        .duty_o      (duty),
        .stall_o     (stall),
        .state_o     (state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                      name, act, act, exp, exp, cyc);
    endtask

    function automatic int map_temp(input int t);
        if (t < T_LO) return D_LO;
        if (t < T_MI) return D_MI;
        if (t < T_HI) return D_HI;
        return P;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_duty = P; m_fan = 1; m_state = 0; m_stall = 0;
        m_kick = 0; m_miss = 0; m_seen = 0; m_cur = P; m_tgt = P;
        th[0] = 0; th[1] = 0; th[2] = 0;
    endtask

    // One clock edge of the behaviour, using the inputs currently on the pins.
    task automatic model_step();
        bit bnd, edge_now;
        if (drv_rst) begin
            model_reset();
            return;
        end
        edge_now = th[1] && !th[2];   // tach seen two clocks late, rising only
        th[2] = th[1]; th[1] = th[0]; th[0] = drv_tach;
        bnd   = (m_cnt == P - 1);
        m_fan = (m_cnt < m_duty);
        case (m_state)
            0: if (bnd) begin
                m_kick++;
                if (m_kick == KP) begin
                    m_state = 1; m_kick = 0; m_cur = P; m_miss = 0; m_seen = 0;
                end
            end
            1: if (bnd) begin
                m_miss = (m_seen || edge_now) ? 0 : m_miss + 1;
                m_seen = 0;
                if (m_miss >= TO) begin
                    m_state = 2; m_stall = 1; m_miss = 0; m_cur = P;
                end else if (m_cur < m_tgt) begin
                    m_cur = (m_cur + STEP < m_tgt) ? m_cur + STEP : m_tgt;
                end else if (m_cur > m_tgt) begin
                    m_cur = (m_cur - STEP > m_tgt) ? m_cur - STEP : m_tgt;
                end
            end else if (edge_now) begin
                m_seen = 1;
            end
            default: if (drv_clr) begin
                m_stall = 0; m_state = 0; m_kick = 0;
            end
        endcase
        if (bnd) m_duty = (m_state == 1) ? m_cur : P;
        if (drv_tv) m_tgt = map_temp(int'(drv_temp));
        m_cnt = bnd ? 0 : m_cnt + 1;
    endtask

    task automatic tick();
        logic [17:0] e;
        cyc++;
        case (tach_mode)
            0:       drv_tach = 1'b0;
            1:       drv_tach = ((cyc / 20) % 2) == 1;
            default: if ($urandom_range(0, 119) == 0) drv_tach = ~drv_tach;
        endcase
        model_step();
        @(negedge clk);
        e = {m_fan[0], m_duty[13:0], m_stall[0], m_state[1:0]};
        check("cycle_model", 32'({fan_ctl, duty, stall, state}), 32'(e));
        drv_tv  = 1'b0;
        drv_clr = 1'b0;
    endtask

    task automatic run_to_boundary();
        int n = 0;
        do begin
            tick();
            n++;
        end while (m_cnt != 0 && n <= P);
    endtask

    typedef struct {
        logic [7:0] temp;
        int         exp_duty;
    } vec_t;

    initial begin
        vec_t vt [8];
        int   hi;
        int   n;

        vt[0] = '{8'd80,  100};
        vt[1] = '{8'd0,   40};
        vt[2] = '{8'd79,  80};
        vt[3] = '{8'd39,  40};
        vt[4] = '{8'd60,  80};
        vt[5] = '{8'd40,  60};
        vt[6] = '{8'd59,  60};
        vt[7] = '{8'd255, 100};

        model_reset();
        @(negedge clk);
        repeat (3) tick();
        check("reset_outputs", 32'({fan_ctl, duty, stall, state}), 32'({1'b1, 14'd100, 1'b0, 2'd0}));
        check("temp_ready", 32'(tif.temp_ready_o), 32'd1);

        // kick-start: full duty for KP periods
        drv_rst = 1'b0;
        hi = 0;
        repeat (199) begin tick(); hi += int'(fan_ctl); end
        check("kick_state_199", 32'(state), 32'd0);
        tick(); hi += int'(fan_ctl);
        check("run_entry_200", 32'(state), 32'd1);
        check("kick_high_200", 32'(hi), 32'd200);
        check("kick_duty", 32'(duty), 32'd100);

        // cool sample: ramp down by STEP each period
        drv_tv = 1'b1; drv_temp = 8'd30;
        for (int i = 0; i < 6; i++) begin
            run_to_boundary();
            check("ramp_down", 32'(duty), 32'(90 - 10 * i));
        end
        hi = 0;
        repeat (P) begin tick(); hi += int'(fan_ctl); end
        check("high_time_40", 32'(hi), 32'd40);

        // hot sample: ramp up to DUTY_HIGH
        drv_tv = 1'b1; drv_temp = 8'd75;
        for (int i = 0; i < 4; i++) begin
            run_to_boundary();
            check("ramp_up", 32'(duty), 32'(50 + 10 * i));
        end
        hi = 0;
        repeat (P) begin tick(); hi += int'(fan_ctl); end
        check("high_time_80", 32'(hi), 32'd80);

        // threshold table, each entry given time to settle
        for (int i = 0; i < 8; i++) begin
            drv_tv = 1'b1; drv_temp = vt[i].temp;
            repeat (7) run_to_boundary();
            check($sformatf("table_temp_%0d", vt[i].temp), 32'(duty), 32'(vt[i].exp_duty));
        end

        // stall: tach stops after an edge was seen in the current period
        repeat (50) tick();
        tach_mode = 0;
        run_to_boundary();
        run_to_boundary();
        check("miss1_state", 32'(state), 32'd1);
        run_to_boundary();
        check("miss2_state", 32'(state), 32'd1);
        n = 0;
        while (m_cnt != P - 1 && n <= P) begin tick(); n++; end
        drv_clr = 1'b1;   // same cycle as stall entry: must be ignored
        tick();
        check("stall_entry", 32'({stall, state, duty}), 32'({1'b1, 2'd2, 14'd100}));
        hi = 0;
        repeat (P) begin tick(); hi += int'(fan_ctl); end
        check("stall_full_on", 32'(hi), 32'(P));
        check("stall_held", 32'({stall, state}), 32'({1'b1, 2'd2}));
        drv_clr = 1'b1;
        tick();
        check("stall_clear", 32'({stall, state}), 32'({1'b0, 2'd0}));
        tach_mode = 1;
        run_to_boundary();
        check("rekick_1", 32'(state), 32'd0);
        run_to_boundary();
        check("rekick_2_run", 32'(state), 32'd1);

        // reset mid-operation
        drv_tv = 1'b1; drv_temp = 8'd10;
        repeat (150) tick();
        drv_rst = 1'b1;
        tick(); tick();
        check("midop_reset", 32'({fan_ctl, duty, stall, state}), 32'({1'b1, 14'd100, 1'b0, 2'd0}));
        drv_rst = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 6000; i++) begin
            if (i % 400 == 0) tach_mode = $urandom_range(0, 2);
            if ($urandom_range(0, 29) == 0) begin
                drv_tv = 1'b1; drv_temp = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 299) == 0) drv_clr = 1'b1;
            drv_rst = ($urandom_range(0, 1999) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fan_speed_sched.md
Name: fan_speed_sched

Overview:
- Closed-loop fan controller. Maps temperature samples to a target PWM duty and slews toward it at a bounded rate.
- Drives the fan PWM pin and runs a full-duty kick-start after reset and after stall recovery.
- Monitors the fan tachometer and flags a stall.
- Sits between the board temperature-sensor reader and the fan connector; replaces fixed-duty fan driving.

Parameters:
- PERIOD, 10000, clocks per PWM period; duty range 0..PERIOD.
- CW, 14, counter/duty width; 2**CW > PERIOD.
- RAMP_STEP, 100, maximum duty change per PWM period.
- KICK_PERIODS, 8, full-duty periods in KICK.
- TACH_TIMEOUT, 4, consecutive tach-less periods that declare a stall.
- T_LOW, 40, temperature threshold 1 (8-bit, degC).
- T_MID, 55, temperature threshold 2.
- T_HIGH, 70, temperature threshold 3.
- DUTY_LOW, 4000, duty for temp < T_LOW.
- DUTY_MID, 6000, duty for T_LOW <= temp < T_MID.
- DUTY_HIGH, 8000, duty for T_MID <= temp < T_HIGH; temp >= T_HIGH uses PERIOD.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- temp_valid_i  in  1  temperature sample valid
- temp_i  in  8  unsigned temperature, degC
- temp_ready_o  out  1  sample accept; constant 1
- tach_i  in  1  fan tach, asynchronous; 2-FF synchronised internally
- stall_clr_i  in  1  single-cycle pulse: leave STALL
- fan_ctl_o  out  1  PWM to fan, high = on
- duty_o  out  CW  duty currently applied
- stall_o  out  1  sticky stall flag
- state_o  out  2  0 = KICK, 1 = RUN, 2 = STALL

Behaviour:
- Reset values:
  - state = KICK, counter = 0, kick count = 0, miss count = 0.
  - target = PERIOD, cur_duty = PERIOD, duty_o = PERIOD.
  - fan_ctl_o = 1, stall_o = 0.
  - Reset mid-operation aborts everything and returns to these values.
- PWM counter runs 0..PERIOD-1 and wraps. The wrap cycle (counter == PERIOD-1) is the period boundary.
- Registered output: fan_ctl_o <= (counter < duty_o), i.e. one cycle of latency.
  - duty 0 gives constant low; duty PERIOD gives constant high.
- duty_o updates only at a period boundary, so it never changes mid-period (no glitched pulses).
- Temperature input:
  - A sample is accepted on temp_valid_i & temp_ready_o, in any state.
  - target is registered on the next clock from the threshold table; comparisons are strict-less-than as listed under Parameters.
- KICK:
  - duty_o = PERIOD.
  - Counts boundaries; at the KICK_PERIODS-th boundary, go to RUN with cur_duty = PERIOD and miss count = 0.
  - Tach is ignored.
- RUN, at each boundary:
  - Slew: if cur_duty < target, cur_duty = min(cur_duty + RAMP_STEP, target); if greater, max(cur_duty - RAMP_STEP, target); otherwise unchanged. Intermediate arithmetic is CW+1 bits with no wrap.
  - duty_o takes the new cur_duty.
- Tach monitoring in RUN:
  - A synchronised rising edge sets a per-period seen flag.
  - At the boundary: if seen, miss count = 0; otherwise miss count + 1. The seen flag then clears.
  - An edge in the boundary cycle itself counts for the ending period.
  - When miss count reaches TACH_TIMEOUT: go to STALL, stall_o = 1, duty_o = PERIOD at that same boundary.
- STALL:
  - Fan held full on; tach ignored.
  - stall_clr_i: stall_o = 0, go to KICK with kick count = 0.
  - stall_clr_i is ignored outside STALL, and in the cycle STALL is entered (stall entry wins).

Optional Feature:
- Macro: FAN_OVERRIDE_EN.
- Defined:
  - Adds ports ovr_en_i (1) and ovr_duty_i (CW).
  - While ovr_en_i = 1, target = min(ovr_duty_i, PERIOD) every cycle and temperature samples are ignored.
  - Slewing, KICK and stall detection are unchanged.
  - On deassertion, target = PERIOD until the next accepted sample.
- Undefined: ports absent; behaviour exactly as above.

Decomposition:
- Shared package (fan_pkg): state encodings KICK/RUN/STALL, state_o width, the default threshold/duty constants, and the PERIOD-relative duty clamp helper.
- One sub-module, fan_pwm_gen: period counter, boundary strobe, duty latch at boundary, registered compare output.
- fan_speed_sched holds the FSM, temp map, slew logic, tach synchroniser and miss counter.

Test Plan:
Sim parameters: PERIOD=100, RAMP_STEP=10, KICK_PERIODS=2, TACH_TIMEOUT=3, thresholds and duties scaled to 40/60/80.
- Reset release, no temp -> fan_ctl_o constant 1 for 200 clocks, state_o 0→1 at clock 200, duty_o stays 100.
- Temp 30 accepted during RUN, tach toggling every 20 clocks -> duty_o steps 90, 80, 70, 60, 50, 40 at successive boundaries; high time 40 of every 100 clocks.
- Temp 30 then 75 -> duty rises by 10 per period to 80; fan_ctl_o high for exactly duty_o clocks per period.
- Tach held low in RUN -> stall_o = 1 and state_o = 2 at the 3rd missed boundary; fan_ctl_o constant 1.
- stall_clr_i pulse in STALL -> stall_o = 0, state_o = 0, 2 full periods, then RUN; the same-cycle clear at stall entry is ignored.
- FAN_OVERRIDE_EN build, ovr_en_i = 1, ovr_duty_i = 200 -> target clamped to 100; a temp sample is ignored; after ovr_en_i drops, target = 100.
